// File: rtl/block_overflow_scan_pkg.sv
// Shared word-format constants, FSM encoding and the block correction rule
// for the block-minifloat overflow scanner.
package block_overflow_scan_pkg;
  localparam int NEXP   = 2;
  localparam int NSIG   = 5;
  localparam int SIZE   = 1 + NEXP + NSIG;
  localparam int WORD_W = NEXP + SIZE;
  localparam logic [NEXP-1:0] EMAX = {NEXP{1'b1}};

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Returns {norm_add, exp_overflow}: any overflow wins, otherwise give the
  // block as much exponent headroom as its largest exponent allows.
  function automatic logic [NEXP:0] block_correction(input logic [NEXP-1:0] max_ovf,
                                                     input logic [NEXP-1:0] max_exp);
    if (max_ovf != '0) return {1'b0, max_ovf};
    return {1'b1, EMAX - max_exp};
  endfunction
endpackage

// File: rtl/block_overflow_scan_bos_block_ram.sv
// One-block buffer: single write port, asynchronous read port.
// Contents are not reset; every slot is rewritten before it is read.
module bos_block_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/block_overflow_scan.sv
// Collects a block of widened minifloats, finds the shared exponent correction,
// then replays the block unchanged with that correction held constant.
module block_overflow_scan
  import block_overflow_scan_pkg::*;
#(
  parameter int BLOCK_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_f,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_f,
  output logic [NEXP-1:0]   exp_overflow,
  output logic              norm_add,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);
  localparam int CW = $clog2(BLOCK_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_LEN - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [NEXP-1:0] max_ovf_q, max_ovf_d;
  logic [NEXP-1:0] max_exp_q, max_exp_d;
  logic [NEXP-1:0] exp_overflow_q, exp_overflow_d;
  logic            norm_add_q, norm_add_d;

  logic [NEXP-1:0]   in_ovf, in_exp, new_ovf, new_exp;
  logic              wr_en;
  logic [WORD_W-1:0] rd_data;

  assign in_ovf  = in_f[WORD_W-1 -: NEXP];
  assign in_exp  = in_f[NSIG +: NEXP];
  assign new_ovf = (in_ovf > max_ovf_q) ? in_ovf : max_ovf_q;
  assign new_exp = (in_exp > max_exp_q) ? in_exp : max_exp_q;

  bos_block_ram #(
    .DEPTH(BLOCK_LEN),
    .WIDTH(WORD_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (count_q),
    .wdata_i (in_f),
    .raddr_i (count_q),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FILL;
      count_q        <= '0;
      max_ovf_q      <= '0;
      max_exp_q      <= '0;
      exp_overflow_q <= '0;
      norm_add_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      max_ovf_q      <= max_ovf_d;
      max_exp_q      <= max_exp_d;
      exp_overflow_q <= exp_overflow_d;
      norm_add_q     <= norm_add_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    max_ovf_d      = max_ovf_q;
    max_exp_d      = max_exp_q;
    exp_overflow_d = exp_overflow_q;
    norm_add_d     = norm_add_q;
    wr_en          = 1'b0;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          wr_en     = 1'b1;
          count_d   = count_q + CW'(1);
          max_ovf_d = new_ovf;
          max_exp_d = new_exp;
          if (count_q == LAST_IDX) begin
            // Correction must include the word being accepted right now.
            state_d = DRAIN;
            count_d = '0;
            {norm_add_d, exp_overflow_d} = block_correction(new_ovf, new_exp);
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          count_d = count_q + CW'(1);
          if (count_q == LAST_IDX) begin
            state_d   = FILL;
            count_d   = '0;
            max_ovf_d = '0;
            max_exp_d = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Everything outside DRAIN is forced to zero so idle outputs never leak stale data.
  assign in_ready     = (state_q == FILL);
  assign out_valid    = (state_q == DRAIN);
  assign out_f        = out_valid ? rd_data : '0;
  assign exp_overflow = out_valid ? exp_overflow_q : '0;
  assign norm_add     = out_valid & norm_add_q;
  assign out_last     = out_valid & (count_q == LAST_IDX);
endmodule

// File: tb/tb_block_overflow_scan.sv
// Directed-plus-random bench for block_overflow_scan with BLOCK_LEN=4.
module tb_block_overflow_scan;
  import block_overflow_scan_pkg::*;

  localparam int BL = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WORD_W-1:0] in_f;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] out_f;
  logic [NEXP-1:0]   exp_overflow;
  logic              norm_add;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] blk [BL];
  int                gaps [BL];

  always #5 clk = ~clk;

  block_overflow_scan #(.BLOCK_LEN(BL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_f         (in_f),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_f        (out_f),
    .exp_overflow (exp_overflow),
    .norm_add     (norm_add),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Build a random word with the given overflow and exponent fields.
  function automatic logic [WORD_W-1:0] mk(input int ovf, input int e);
    logic [WORD_W-1:0] w;
    w = WORD_W'($urandom);
    w[WORD_W-1 -: NEXP] = NEXP'(ovf);
    w[NSIG +: NEXP]     = NEXP'(e);
    return w;
  endfunction

  // Reference: largest overflow, else headroom from largest exponent.
  task automatic model(output int exp_ovf, output int nadd);
    int mo = 0, me = 0;
    for (int i = 0; i < BL; i++) begin
      if (int'(blk[i][WORD_W-1 -: NEXP]) > mo) mo = int'(blk[i][WORD_W-1 -: NEXP]);
      if (int'(blk[i][NSIG +: NEXP]) > me) me = int'(blk[i][NSIG +: NEXP]);
    end
    if (mo != 0) begin exp_ovf = mo; nadd = 0; end
    else begin exp_ovf = (1 << NEXP) - 1 - me; nadd = 1; end
  endtask

  // Called at a negedge; returns at the negedge right after the last accept.
  task automatic fill_block(input string name);
    for (int i = 0; i < BL; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        in_valid = 1'b0;
        chk({name, ".gap_in_ready"}, 32'(in_ready), 32'd1);
        chk({name, ".gap_out_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
      end
      chk({name, ".fill_in_ready"}, 32'(in_ready), 32'd1);
      chk({name, ".fill_out_valid"}, 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_f     = blk[i];
      $display("fill %s word %0d in_f=%0h", name, i, blk[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_f     = WORD_W'($urandom);
  endtask

  task automatic check_word(input string name, input int idx, input int eo, input int na);
    chk({name, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({name, ".in_ready_drain"}, 32'(in_ready), 32'd0);
    chk({name, ".out_f"}, 32'(out_f), 32'(blk[idx]));
    chk({name, ".exp_overflow"}, 32'(exp_overflow), 32'(eo));
    chk({name, ".norm_add"}, 32'(norm_add), 32'(na));
    chk({name, ".out_last"}, 32'(out_last), 32'(idx == BL - 1));
  endtask

  // Starts at the negedge where out_valid should already be high.
  task automatic drain_block(input string name, input int stall_at, input int stall_n);
    int eo, na;
    model(eo, na);
    for (int i = 0; i < BL; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check_word({name, ".stall"}, i, eo, na);
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      check_word(name, i, eo, na);
      $display("drain %s word %0d out_f=%0h exp_overflow=%0d norm_add=%0d last=%0b",
               name, i, out_f, exp_overflow, norm_add, out_last);
      @(negedge clk);
    end
    chk({name, ".post_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, ".post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic reset_outputs(input string name);
    chk({name, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({name, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({name, ".out_f"}, 32'(out_f), 32'd0);
    chk({name, ".exp_overflow"}, 32'(exp_overflow), 32'd0);
    chk({name, ".norm_add"}, 32'(norm_add), 32'd0);
    chk({name, ".out_last"}, 32'(out_last), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_f = '0; out_ready = 1'b1;
    for (int i = 0; i < BL; i++) gaps[i] = 0;
    #3;
    reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: overflow present, largest overflow wins.
    blk[0] = mk(0, $urandom_range(3)); blk[1] = mk(2, $urandom_range(3));
    blk[2] = mk(1, $urandom_range(3)); blk[3] = mk(0, $urandom_range(3));
    fill_block("t1"); drain_block("t1", -1, 0);

    // Test 2: no overflow, max exp 2 -> headroom 1.
    blk[0] = mk(0, 1); blk[1] = mk(0, 0); blk[2] = mk(0, 2); blk[3] = mk(0, 1);
    fill_block("t2"); drain_block("t2", -1, 0);

    // Test 3: all-zero exponents, then a block touching EMAX.
    for (int i = 0; i < BL; i++) blk[i] = mk(0, 0);
    fill_block("t3a"); drain_block("t3a", -1, 0);
    for (int i = 0; i < BL; i++) blk[i] = mk(0, $urandom_range(2));
    blk[$urandom_range(BL - 1)] = mk(0, 3);
    fill_block("t3b"); drain_block("t3b", -1, 0);

    // Test 4: downstream stall of 3 cycles after word 2.
    for (int i = 0; i < BL; i++) blk[i] = mk($urandom_range(3), $urandom_range(3));
    fill_block("t4"); drain_block("t4", 2, 3);

    // Test 5: partial fill with large overflow, then async reset between edges.
    in_valid = 1'b1; in_f = mk(3, 3); @(negedge clk);
    in_f = mk(3, 3); @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_outputs("t5_rst_fill");
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    blk[0] = mk(1, 0); blk[1] = mk(0, 0); blk[2] = mk(0, 0); blk[3] = mk(0, 0);
    fill_block("t5"); drain_block("t5", -1, 0);

    // Reset mid-drain clears outputs immediately and discards the block.
    for (int i = 0; i < BL; i++) blk[i] = mk(2, $urandom_range(3));
    fill_block("t5d");
    out_ready = 1'b1; @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_outputs("t5_rst_drain");
    @(negedge clk); rst_n = 1'b1; @(negedge clk);

    // Test 6: gappy fill then back-to-back independent block.
    gaps[0] = 0; gaps[1] = 2; gaps[2] = 0; gaps[3] = 1;
    for (int i = 0; i < BL; i++) blk[i] = mk(0, $urandom_range(1));
    fill_block("t6a"); drain_block("t6a", -1, 0);
    for (int i = 0; i < BL; i++) gaps[i] = 0;
    for (int i = 0; i < BL; i++) blk[i] = mk($urandom_range(3), $urandom_range(3));
    fill_block("t6b"); drain_block("t6b", -1, 0);

    // Random blocks with random gaps and stalls.
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < BL; i++) begin
        gaps[i] = $urandom_range(2);
        blk[i]  = mk(($urandom_range(1) == 0) ? 0 : $urandom_range(3), $urandom_range(3));
      end
      fill_block("rnd");
      drain_block("rnd", $urandom_range(BL - 1), $urandom_range(2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
